// File: rtl/register_unloader_if.sv
`default_nettype none
// ============================================================================
// register_unloader_if : parallel load / serial valid-ready bundle  (Rev 1.0)
// ============================================================================
interface register_unloader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             load;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             sready;
  logic             busy;
  logic             done;

  modport master (
    output data, load, sready,
    input  ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  data, load, sready,
    output ready, sout, sout_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/register_unloader.sv
`default_nettype none
// ============================================================================
// register_unloader : captures a parallel word and shifts it out serially
// Rev 1.0
// ============================================================================
module register_unloader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic            clk,
  input  wire logic            rst_,
  register_unloader_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ready;
  logic              r_sout_valid;
  logic              r_busy;
  logic              r_done;

  logic [WIDTH-1:0]  w_shifted;
  logic              w_out_bit;
  logic              w_xfer;

  // The register drains to all-zeros on a completed word and is cleared by
  // reset, so its output end is already 0 in IDLE and DONE without gating.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
      assign w_out_bit = r_shreg[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
      assign w_out_bit = r_shreg[0];
    end
  endgenerate

  assign w_xfer = r_sout_valid & bus.sready;

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_shreg      <= bus.data;
            r_cnt        <= C_LAST;
            r_state      <= S_SHIFT;
            r_ready      <= 1'b0;
            r_busy       <= 1'b1;
            r_sout_valid <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_xfer) begin
            r_shreg <= w_shifted;
            if (r_cnt == '0) begin
              r_state      <= S_DONE;
              r_sout_valid <= 1'b0;
              r_done       <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_shreg      <= '0;
          r_cnt        <= '0;
          r_ready      <= 1'b1;
          r_sout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready      = r_ready;
  assign bus.sout       = w_out_bit;
  assign bus.sout_valid = r_sout_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_register_unloader.sv
`default_nettype none
// ============================================================================
// tb_register_unloader : MSB-first and LSB-first instances driven in lockstep
// Rev 1.0
// ============================================================================
module tb_register_unloader;
  logic clk = 1'b0;
  logic rst_;
  int   checks = 0;
  int   errors = 0;

  register_unloader_if #(.WIDTH(8)) bm ();
  register_unloader_if #(.WIDTH(8)) bl ();

  register_unloader #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_(rst_), .bus(bm));
  register_unloader #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_(rst_), .bus(bl));

  always #5 clk = ~clk;

  // Scoreboard: expected serial bits and expected done pulses per instance.
  logic qm[$];
  logic ql[$];
  int   dm = 0;
  int   dl = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [7:0] d, input logic sr);
    bm.load = ld; bl.load = ld;
    bm.data = d;  bl.data = d;
    bm.sready = sr; bl.sready = sr;
  endtask

  task automatic push_word(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      qm.push_back(d[7-i]);
      ql.push_back(d[i]);
    end
    dm++;
    dl++;
  endtask

  task automatic check_idle(input string tag);
    check1({tag, "_msb_ready"}, bm.ready, 1'b1);
    check1({tag, "_msb_busy"}, bm.busy, 1'b0);
    check1({tag, "_msb_valid"}, bm.sout_valid, 1'b0);
    check1({tag, "_msb_sout"}, bm.sout, 1'b0);
    check1({tag, "_msb_done"}, bm.done, 1'b0);
    check1({tag, "_lsb_ready"}, bl.ready, 1'b1);
    check1({tag, "_lsb_valid"}, bl.sout_valid, 1'b0);
    check1({tag, "_lsb_done"}, bl.done, 1'b0);
  endtask

  // Called in cycle 1 of a word; stalls sready during cycles [sfrom, sto].
  task automatic finish_word(input int c0, input int sfrom, input int sto);
    int  left = 8;
    int  c = c0;
    logic sr;
    while (left > 0) begin
      sr = !(c >= sfrom && c <= sto);
      bm.sready = sr; bl.sready = sr;
      check1("shift_msb_valid", bm.sout_valid, 1'b1);
      check1("shift_lsb_valid", bl.sout_valid, 1'b1);
      check1("shift_msb_ready", bm.ready, 1'b0);
      if (qm.size() > 0) check1("shift_msb_sout_now", bm.sout, qm[0]);
      if (ql.size() > 0) check1("shift_lsb_sout_now", bl.sout, ql[0]);
      if (sr) left--;
      tick();
      c++;
    end
    bm.sready = 1'b1; bl.sready = 1'b1;
    check1("done_msb_pulse", bm.done, 1'b1);
    check1("done_lsb_pulse", bl.done, 1'b1);
    check1("done_msb_valid", bm.sout_valid, 1'b0);
    check1("done_msb_busy", bm.busy, 1'b1);
    check1("done_msb_ready", bm.ready, 1'b0);
    check1("done_msb_sout", bm.sout, 1'b0);
    tick();
    check_idle("after_done");
  endtask

  task automatic run_word(input logic [7:0] d, input int sfrom, input int sto);
    drive(1'b1, d, 1'b1);
    tick();
    push_word(d);
    drive(1'b0, 8'h00, 1'b1);
    finish_word(1, sfrom, sto);
  endtask

  // Monitor: consumes one expected bit per accepted transfer.
  always @(negedge clk) begin
    if (rst_ === 1'b0) begin
      if (bm.sout_valid && bm.sready) begin
        if (qm.size() == 0) checki("msb_extra_bit", 1, 0);
        else check1("msb_bit", bm.sout, qm.pop_front());
      end
      if (bl.sout_valid && bl.sready) begin
        if (ql.size() == 0) checki("lsb_extra_bit", 1, 0);
        else check1("lsb_bit", bl.sout, ql.pop_front());
      end
      if (bm.done) begin
        checki("msb_done_expected", dm, 1);
        checki("msb_done_bits_left", qm.size(), 0);
        if (dm > 0) dm--;
      end
      if (bl.done) begin
        checki("lsb_done_expected", dl, 1);
        checki("lsb_done_bits_left", ql.size(), 0);
        if (dl > 0) dl--;
      end
      check1("msb_ready_vs_busy", bm.ready, !bm.busy);
      check1("lsb_ready_vs_busy", bl.ready, !bl.busy);
      if (!bm.sout_valid) check1("msb_sout_quiet", bm.sout, 1'b0);
      if (!bl.sout_valid) check1("lsb_sout_quiet", bl.sout, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    rst_ = 1'b0;
    check_idle("reset");

    // MSB-first A5 / LSB-first A5, no stall
    run_word(8'hA5, 0, -1);
    // 01: LSB instance emits 1 then seven 0s
    run_word(8'h01, 0, -1);
    // A5 with sready low in cycles 3-4: done moves to cycle 11
    run_word(8'hA5, 3, 4);

    // 00 transfer with load/FF held from cycle 2: capture only at edge 10
    drive(1'b1, 8'h00, 1'b1);
    tick();
    push_word(8'h00);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b1, 8'hFF, 1'b1);
    for (int c = 2; c <= 9; c++) begin
      check1("ignored_load_msb_ready", bm.ready, 1'b0);
      check1("ignored_load_msb_sout", bm.sout, 1'b0);
      check1("ignored_load_lsb_sout", bl.sout, 1'b0);
      tick();
    end
    check1("cycle10_msb_ready", bm.ready, 1'b1);
    check1("cycle10_lsb_ready", bl.ready, 1'b1);
    tick();
    push_word(8'hFF);
    drive(1'b0, 8'h00, 1'b1);
    finish_word(1, 0, -1);

    // Reset at edge 4 of an A5 transfer discards the word
    drive(1'b1, 8'hA5, 1'b1);
    tick();
    push_word(8'hA5);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    qm.delete();
    ql.delete();
    dm = 0;
    dl = 0;
    check_idle("mid_reset");
    tick();
    check_idle("mid_reset_next");
    run_word(8'h3C, 0, -1);
    run_word(8'h3C, 2, 2);

    tick();
    checki("msb_pending_bits", qm.size(), 0);
    checki("lsb_pending_bits", ql.size(), 0);
    checki("msb_pending_done", dm, 0);
    checki("lsb_pending_done", dl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/register_unloader.md
REGISTER_UNLOADER -- requirements
Module: register_unloader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = serialize MSB first, 0 = serialize LSB first.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port data, input, WIDTH bits: the parallel word to unload.
REQ-006 The block SHALL have port load, input, 1 bit: request to capture data.
REQ-007 The block SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-008 The block SHALL have port sout, output, 1 bit: the current serial bit.
REQ-009 The block SHALL have port sout_valid, output, 1 bit: high when sout carries a valid bit.
REQ-010 The block SHALL have port sready, input, 1 bit: downstream accepts sout on this edge.
REQ-011 The block SHALL have port busy, output, 1 bit: high in SHIFT or DONE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit is accepted.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 IDLE SHALL drive ready=1, busy=0, sout_valid=0, sout=0 and done=0.
REQ-015 In IDLE, load=1 at an edge SHALL capture data into the shift register, load the bit counter with WIDTH-1, and enter SHIFT.
REQ-016 Latency from load to valid output SHALL be one cycle: first bit on sout with sout_valid=1 in the cycle after the capture edge.
REQ-017 SHIFT SHALL drive ready=0, busy=1 and sout_valid=1.
REQ-018 In SHIFT, sout SHALL be shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
REQ-019 A bit SHALL be transferred only at an edge where sout_valid=1 and sready=1.
REQ-020 On a transfer, the shift register SHALL shift by one toward the output end, zero-filling, and the counter SHALL decrement.
REQ-021 While sready=0 in SHIFT, sout, the counter and the shift register SHALL hold unchanged (stall of any length).
REQ-022 A transfer with counter=0 SHALL enter DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, busy=1, ready=0, sout_valid=0 and sout=0, then return to IDLE.
REQ-024 load asserted in SHIFT or DONE SHALL be ignored: no capture, no queuing, and the in-flight word is unaffected.
REQ-025 Back-to-back words SHALL be possible: load held high gives the next capture on the first IDLE edge, i.e. one idle cycle between words.
REQ-026 The bit count per word SHALL be exactly WIDTH; the counter SHALL be sized clog2(WIDTH) bits and never wrap below 0.

Reset
REQ-027 When rst_=1 at an edge, the block SHALL enter IDLE, clear the shift register and counter, and drive ready=1 with all other outputs 0 from the next cycle.
REQ-028 Reset SHALL take priority over load and sready at the same edge, including mid-SHIFT and in DONE; a word interrupted by reset is discarded, with no done pulse.
REQ-029 No output SHALL change asynchronously with rst_.

Verification
REQ-030 MSB_FIRST=1, data=8'hA5 loaded at edge 0, sready=1 -> sout=1,0,1,0,0,1,0,1 in cycles 1-8 with sout_valid=1, done=1 in cycle 9, ready=1 in cycle 10.
REQ-031 MSB_FIRST=0, data=8'h01, sready=1 -> sout=1 in cycle 1, then 0 in cycles 2-8, then done in cycle 9.
REQ-032 data=8'hA5 with sready=0 during cycles 3-4 -> bit index 5 (value 1) held on sout for cycles 3-5, last bit in cycle 10, done in cycle 11.
REQ-033 load=1 with data=8'hFF during cycles 2-9 of an 8'h00 transfer -> sout stays 0 throughout, and 8'hFF is captured only at the first IDLE edge (edge 10).
REQ-034 rst_=1 at edge 4 of an 8'hA5 transfer -> cycle 5 shows ready=1, busy=0, sout_valid=0, sout=0, no done pulse; a new load of 8'h3C then serializes correctly.
